// File: rtl/exe_stage.sv
// Execute stage: two-slot pipeline (S1 issued operands, S2 ALU result) with
// valid/ready handshakes on both sides and S2/writeback operand forwarding.
module exe_stage #(
  parameter int unsigned FWD_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_dec_valid,
  output logic        o_dec_ready,
  input  logic [7:0]  i_dec_command,
  input  logic [4:0]  i_dec_rd,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic        i_dec_wen,
  input  logic        i_dec_use_imm,
  input  logic [31:0] i_dec_rs1_data,
  input  logic [31:0] i_dec_rs2_data,
  input  logic [31:0] i_dec_imm,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic [7:0]  o_alu_command,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  input  logic [31:0] i_alu_out,
  input  logic        i_alu_zero,
  output logic        o_ex_valid,
  input  logic        i_ex_ready,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_wen,
  output logic [31:0] o_ex_result,
  output logic        o_ex_zero
);

  logic        s1_valid;
  logic [7:0]  s1_command;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic        s1_wen;
  logic        s1_use_imm;
  logic [31:0] s1_rs1_data;
  logic [31:0] s1_rs2_data;
  logic [31:0] s1_imm;

  logic        s2_valid;
  logic [4:0]  s2_rd;
  logic        s2_wen;
  logic [31:0] s2_result;
  logic        s2_zero;

  logic        s2_free;
  logic        s1_adv;
  logic        dec_accept;
  logic        wb_hit_rs1;
  logic        wb_hit_rs2;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  // x0 always reads zero; the younger S2 result wins over the older writeback.
  function automatic logic [31:0] fwd(
    input logic [4:0]  rs,
    input logic [31:0] stored,
    input logic        s2_hit_valid,
    input logic [4:0]  s2_hit_rd,
    input logic [31:0] s2_hit_data,
    input logic        wb_hit_valid,
    input logic [4:0]  wb_hit_rd,
    input logic [31:0] wb_hit_data
  );
    if (rs == 5'd0) return 32'd0;
    if (FWD_EN == 0) return stored;
    if (s2_hit_valid && (s2_hit_rd == rs)) return s2_hit_data;
    if (wb_hit_valid && (wb_hit_rd == rs)) return wb_hit_data;
    return stored;
  endfunction

  assign s2_free     = !s2_valid || i_ex_ready;
  assign s1_adv      = s1_valid && s2_free;
  assign o_dec_ready = !i_flush && (!s1_valid || s1_adv);
  assign dec_accept  = i_dec_valid && o_dec_ready;

  assign wb_hit_rs1 = i_wb_valid && (i_wb_rd == s1_rs1) && (s1_rs1 != 5'd0);
  assign wb_hit_rs2 = i_wb_valid && (i_wb_rd == s1_rs2) && (s1_rs2 != 5'd0);

  always_comb begin
    rs1_fwd = fwd(s1_rs1, s1_rs1_data, s2_valid && s2_wen, s2_rd, s2_result,
                  i_wb_valid, i_wb_rd, i_wb_data);
    rs2_fwd = fwd(s1_rs2, s1_rs2_data, s2_valid && s2_wen, s2_rd, s2_result,
                  i_wb_valid, i_wb_rd, i_wb_data);
  end

  assign o_alu_command = s1_valid ? s1_command : 8'h0;
  assign o_alu_a       = rs1_fwd;
  assign o_alu_b       = s1_use_imm ? s1_imm : rs2_fwd;

  assign o_ex_valid  = s2_valid;
  assign o_ex_rd     = s2_rd;
  assign o_ex_wen    = s2_wen;
  assign o_ex_result = s2_result;
  assign o_ex_zero   = s2_zero;

  // Flush outranks accept and advance; a held S1 soaks up writebacks so a
  // forward that only appears during the stall is not lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1_command  <= 8'h0;
      s1_rd       <= 5'd0;
      s1_rs1      <= 5'd0;
      s1_rs2      <= 5'd0;
      s1_wen      <= 1'b0;
      s1_use_imm  <= 1'b0;
      s1_rs1_data <= 32'd0;
      s1_rs2_data <= 32'd0;
      s1_imm      <= 32'd0;
      s2_valid    <= 1'b0;
      s2_rd       <= 5'd0;
      s2_wen      <= 1'b0;
      s2_result   <= 32'd0;
      s2_zero     <= 1'b0;
    end else if (i_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (dec_accept) begin
        s1_valid    <= 1'b1;
        s1_command  <= i_dec_command;
        s1_rd       <= i_dec_rd;
        s1_rs1      <= i_dec_rs1;
        s1_rs2      <= i_dec_rs2;
        s1_wen      <= i_dec_wen;
        s1_use_imm  <= i_dec_use_imm;
        s1_rs1_data <= i_dec_rs1_data;
        s1_rs2_data <= i_dec_rs2_data;
        s1_imm      <= i_dec_imm;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end else if (s1_valid && (FWD_EN != 0)) begin
        if (wb_hit_rs1) s1_rs1_data <= i_wb_data;
        if (wb_hit_rs2) s1_rs2_data <= i_wb_data;
      end

      if (s1_adv) begin
        s2_valid  <= 1'b1;
        s2_rd     <= s1_rd;
        s2_wen    <= s1_wen;
        s2_result <= i_alu_out;
        s2_zero   <= i_alu_zero;
      end else if (i_ex_ready && s2_valid) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios plus a random stream, checked against
// an in-order architectural model (register file + queue of issued instructions).
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [7:0]  dec_command;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_wen;
  logic        dec_use_imm;
  logic [31:0] dec_rs1_data;
  logic [31:0] dec_rs2_data;
  logic [31:0] dec_imm;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [7:0]  alu_command;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic [31:0] ex_result;
  logic        ex_zero;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wen;
    logic        use_imm;
    logic [31:0] imm;
  } instr_t;

  logic [31:0] ref_rf [32];
  logic [31:0] hw_rf [32];
  instr_t      pend_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          force_wb0 = 1'b0;

  always #5 clk = ~clk;

  exe_stage dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_dec_valid    (dec_valid),
    .o_dec_ready    (dec_ready),
    .i_dec_command  (dec_command),
    .i_dec_rd       (dec_rd),
    .i_dec_rs1      (dec_rs1),
    .i_dec_rs2      (dec_rs2),
    .i_dec_wen      (dec_wen),
    .i_dec_use_imm  (dec_use_imm),
    .i_dec_rs1_data (dec_rs1_data),
    .i_dec_rs2_data (dec_rs2_data),
    .i_dec_imm      (dec_imm),
    .i_wb_valid     (wb_valid),
    .i_wb_rd        (wb_rd),
    .i_wb_data      (wb_data),
    .o_alu_command  (alu_command),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .i_alu_out      (alu_out),
    .i_alu_zero     (alu_zero),
    .o_ex_valid     (ex_valid),
    .i_ex_ready     (ex_ready),
    .o_ex_rd        (ex_rd),
    .o_ex_wen       (ex_wen),
    .o_ex_result    (ex_result),
    .o_ex_zero      (ex_zero)
  );

  // External combinational ALU the stage drives.
  function automatic logic [31:0] alu_ref(input logic [7:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    case (cmd)
      8'h1:    return a + b;
      8'h2:    return a - b;
      8'h3:    return a & b;
      8'h4:    return a | b;
      8'h5:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_out  = alu_ref(alu_command, alu_a, alu_b);
  assign alu_zero = (alu_out == 32'd0);

  function automatic logic [31:0] arch_operand(input logic [4:0] rs);
    return (rs == 5'd0) ? 32'd0 : ref_rf[rs];
  endfunction

  function automatic logic [31:0] model_result(input instr_t ins);
    return alu_ref(ins.cmd, arch_operand(ins.rs1),
                   ins.use_imm ? ins.imm : arch_operand(ins.rs2));
  endfunction

  // Register-file read port with write-through; x0 data is deliberately garbage.
  function automatic logic [31:0] hw_read(input logic [4:0] rs);
    if (rs == 5'd0) return $urandom;
    if (wb_valid && (wb_rd == rs)) return wb_data;
    return hw_rf[rs];
  endfunction

  function automatic instr_t mk(input logic [7:0] cmd, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic wen, input logic use_imm, input logic [31:0] imm);
    instr_t ins;
    ins.cmd = cmd; ins.rd = rd; ins.rs1 = rs1; ins.rs2 = rs2;
    ins.wen = wen; ins.use_imm = use_imm; ins.imm = imm;
    return ins;
  endfunction

  function automatic instr_t rand_instr();
    return mk(8'($urandom_range(1, 5)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at negedge, check just before posedge, update model after it.
  task automatic applyStimulus(input logic v, input instr_t ins, input logic rdy,
                               input logic fl, output logic accepted);
    logic        exp_ready;
    logic        retire;
    logic [4:0]  ret_rd;
    logic        ret_wen;
    logic [31:0] ret_data;
    logic [31:0] res;
    instr_t      head;
    @(negedge clk);
    flush     = fl;
    ex_ready  = rdy;
    dec_valid = v;
    if (v) begin
      dec_command = ins.cmd; dec_rd = ins.rd; dec_rs1 = ins.rs1; dec_rs2 = ins.rs2;
      dec_wen = ins.wen; dec_use_imm = ins.use_imm; dec_imm = ins.imm;
      dec_rs1_data = hw_read(ins.rs1);
      dec_rs2_data = hw_read(ins.rs2);
    end else begin
      dec_command = 8'($urandom); dec_rd = 5'($urandom); dec_rs1 = 5'($urandom);
      dec_rs2 = 5'($urandom); dec_wen = 1'($urandom); dec_use_imm = 1'($urandom);
      dec_imm = $urandom; dec_rs1_data = $urandom; dec_rs2_data = $urandom;
    end
    #4;
    exp_ready = !fl && ((pend_q.size() < 2) || rdy);
    checkOutput("dec_ready", 32'(dec_ready), 32'(exp_ready));
    retire = 1'b0; ret_rd = 5'd0; ret_wen = 1'b0; ret_data = 32'd0;
    if (ex_valid) begin
      if (pend_q.size() == 0) begin
        checkOutput("ex_valid_spurious", 32'(ex_valid), 32'd0);
      end else begin
        head = pend_q[0];
        res  = model_result(head);
        checkOutput("ex_result", ex_result, res);
        checkOutput("ex_zero", 32'(ex_zero), 32'(res == 32'd0));
        checkOutput("ex_rd", 32'(ex_rd), 32'(head.rd));
        checkOutput("ex_wen", 32'(ex_wen), 32'(head.wen));
        retire = rdy && !fl;
        ret_rd = ex_rd; ret_wen = ex_wen; ret_data = ex_result;
      end
    end
    accepted = v && exp_ready;
    @(posedge clk);
    #1;
    if (wb_valid && (wb_rd != 5'd0)) hw_rf[wb_rd] = wb_data;
    if (force_wb0) begin
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hdeadbeef;
    end else if (retire && ret_wen) begin
      wb_valid = 1'b1; wb_rd = ret_rd; wb_data = ret_data;
    end else begin
      wb_valid = 1'b0; wb_rd = 5'($urandom); wb_data = $urandom;
    end
    if (retire) begin
      head = pend_q.pop_front();
      res  = model_result(head);
      if (head.wen && (head.rd != 5'd0)) ref_rf[head.rd] = res;
    end
    if (fl) pend_q.delete();
    if (accepted) pend_q.push_back(ins);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    checkOutput({tag, "_ex_result"}, ex_result, 32'd0);
    checkOutput({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
    checkOutput({tag, "_ex_wen"}, 32'(ex_wen), 32'd0);
    checkOutput({tag, "_ex_zero"}, 32'(ex_zero), 32'd0);
    checkOutput({tag, "_alu_cmd"}, 32'(alu_command), 32'd0);
    checkOutput({tag, "_alu_a"}, alu_a, 32'd0);
    checkOutput({tag, "_alu_b"}, alu_b, 32'd0);
    checkOutput({tag, "_dec_ready"}, 32'(dec_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    instr_t cur;
    instr_t ia;
    instr_t ib;
    instr_t ic;
    logic   acc;
    logic   have;

    rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b0;
    dec_command = 8'h0; dec_rd = 5'd0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    dec_wen = 1'b0; dec_use_imm = 1'b0; dec_imm = 32'd0;
    dec_rs1_data = 32'd0; dec_rs2_data = 32'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hdeadbeef;
    ref_rf[0] = 32'd0; hw_rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      ref_rf[i] = $urandom;
      hw_rf[i]  = ref_rf[i];
    end
    ref_rf[3] = 32'd5;    hw_rf[3] = 32'd5;
    ref_rf[6] = 32'd3;    hw_rf[6] = 32'd3;
    ref_rf[7] = 32'd4;    hw_rf[7] = 32'd4;
    ref_rf[5] = 32'h55;   hw_rf[5] = 32'h55;

    // Power-on reset
    @(posedge clk);
    #1;
    checkResetOutputs("por");
    rst = 1'b0;
    wb_valid = 1'b0;

    // Simple stream: 5 + imm 7 with exact two-cycle latency
    ia = mk(8'h1, 5'd4, 5'd3, 5'd9, 1'b1, 1'b1, 32'd7);
    applyStimulus(1'b1, ia, 1'b1, 1'b0, acc);
    checkOutput("lat_s1_only", 32'(ex_valid), 32'd0);
    applyStimulus(1'b0, ia, 1'b1, 1'b0, acc);
    checkOutput("lat_ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("stream_result", ex_result, 32'd12);
    checkOutput("stream_zero", 32'(ex_zero), 32'd0);
    applyStimulus(1'b0, ia, 1'b1, 1'b0, acc);

    // Back-to-back dependency: x1 = 3 + 4, x2 = x1 - 7
    ia = mk(8'h1, 5'd1, 5'd6, 5'd7, 1'b1, 1'b0, 32'd0);
    ib = mk(8'h2, 5'd2, 5'd1, 5'd0, 1'b1, 1'b1, 32'd7);
    applyStimulus(1'b1, ia, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, ib, 1'b1, 1'b0, acc);
    checkOutput("dep_first", ex_result, 32'd7);
    applyStimulus(1'b0, ib, 1'b1, 1'b0, acc);
    checkOutput("dep_no_bubble", 32'(ex_valid), 32'd1);
    checkOutput("dep_result", ex_result, 32'd0);
    checkOutput("dep_zero", 32'(ex_zero), 32'd1);
    applyStimulus(1'b0, ib, 1'b1, 1'b0, acc);

    // Writeback of x5 arrives only while the consumer is stalled in S1
    ia = mk(8'h1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 32'h10);
    ib = mk(8'h3, 5'd9, 5'd2, 5'd2, 1'b1, 1'b0, 32'd0);
    ic = mk(8'h1, 5'd10, 5'd5, 5'd0, 1'b1, 1'b1, 32'd0);
    applyStimulus(1'b1, ia, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, ib, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, ic, 1'b1, 1'b0, acc);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, ic, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, ic, 1'b1, 1'b0, acc);
    checkOutput("wb_stall_fwd", ex_result, 32'h10);
    applyStimulus(1'b0, ic, 1'b1, 1'b0, acc);

    // Backpressure: four stalled cycles under continuous input
    have = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!have) begin
        cur  = rand_instr();
        have = 1'b1;
      end
      applyStimulus(1'b1, cur, (k >= 4), 1'b0, acc);
      if (acc) have = 1'b0;
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, cur, 1'b1, 1'b0, acc);
    checkOutput("bp_drained", 32'(pend_q.size()), 32'd0);

    // Flush with both slots full while decode keeps offering
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, rand_instr(), 1'b0, 1'b0, acc);
    applyStimulus(1'b1, rand_instr(), 1'b0, 1'b1, acc);
    checkOutput("flush_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush_s1_empty", 32'(alu_command), 32'd0);
    applyStimulus(1'b0, ia, 1'b1, 1'b0, acc);
    checkOutput("flush_no_ghost", 32'(ex_valid), 32'd0);

    // Asynchronous reset mid-stream, then x0 operands against a wb to x0
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, rand_instr(), 1'b0, 1'b0, acc);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    if (wb_valid && (wb_rd != 5'd0)) hw_rf[wb_rd] = wb_data;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hdeadbeef;
    dec_valid = 1'b0;
    pend_q.delete();
    @(posedge clk);
    #1;
    checkResetOutputs("rst_held");
    rst = 1'b0;
    force_wb0 = 1'b1;
    ia = mk(8'h1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 32'd9);
    ib = mk(8'h4, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, ia, 1'b1, 1'b0, acc);
    checkOutput("rst_resume_cmd", 32'(alu_command), 32'd1);
    checkOutput("x0_alu_a", alu_a, 32'd0);
    applyStimulus(1'b1, ib, 1'b1, 1'b0, acc);
    checkOutput("x0_result", ex_result, 32'd9);
    checkOutput("x0_alu_b", alu_b, 32'd0);
    force_wb0 = 1'b0;
    applyStimulus(1'b0, ib, 1'b1, 1'b0, acc);
    checkOutput("x0_or_result", ex_result, 32'd0);
    checkOutput("x0_or_zero", 32'(ex_zero), 32'd1);
    applyStimulus(1'b0, ib, 1'b1, 1'b0, acc);

    // Random stream with random backpressure and hazards on x0..x7
    have = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!have) begin
        cur  = rand_instr();
        have = ($urandom_range(0, 9) < 7);
      end
      applyStimulus(have, cur, ($urandom_range(0, 3) != 0), 1'b0, acc);
      if (acc) have = 1'b0;
    end
    for (int n = 0; (n < 20) && (pend_q.size() > 0); n++)
      applyStimulus(1'b0, cur, 1'b1, 1'b0, acc);
    checkOutput("drain_left", 32'(pend_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter FWD_EN, default 1, meaning 1 enables operand forwarding and 0 always uses the captured register-file data.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_flush  input  1  synchronous pipeline kill.
REQ-005 SHALL have ports i_dec_valid in 1 / o_dec_ready out 1  decode-side handshake.
REQ-006 SHALL have ports i_dec_command in 8, i_dec_rd/i_dec_rs1/i_dec_rs2 in 5 each, i_dec_wen in 1, i_dec_use_imm in 1  decoded instruction fields.
REQ-007 SHALL have ports i_dec_rs1_data/i_dec_rs2_data/i_dec_imm in 32 each  operand data.
REQ-008 SHALL have ports i_wb_valid in 1, i_wb_rd in 5, i_wb_data in 32  writeback forwarding source.
REQ-009 SHALL have ports o_alu_command out 8, o_alu_a out 32, o_alu_b out 32, i_alu_out in 32, i_alu_zero in 1  connection to the ALU, which is purely combinational.
REQ-010 SHALL have ports o_ex_valid out 1 / i_ex_ready in 1, o_ex_rd out 5, o_ex_wen out 1, o_ex_result out 32, o_ex_zero out 1  result side.

Function
REQ-011 SHALL hold two registered slots: S1 (issued operands) and S2 (ALU result); accept-to-o_ex_valid latency is exactly 2 cycles when unstalled.
REQ-012 SHALL define s2_free = !s2_valid || i_ex_ready and s1_adv = s1_valid && s2_free.
REQ-013 SHALL drive o_dec_ready = !i_flush && (!s1_valid || s1_adv), combinationally.
REQ-014 SHALL load S1 with all decode fields on i_dec_valid && o_dec_ready.
REQ-015 SHALL, when s1_adv, load S2 with i_alu_out, i_alu_zero, rd and wen from S1, and set s2_valid.
REQ-016 SHALL clear s2_valid when i_ex_ready && s2_valid && !s1_adv.
REQ-017 SHALL clear s1_valid when s1_adv occurs without a simultaneous accept.
REQ-018 SHALL drive o_alu_command from S1 and 8'h0 when !s1_valid.
REQ-019 SHALL drive o_alu_a = fwd(rs1) and o_alu_b = S1.use_imm ? S1.imm : fwd(rs2).
REQ-020 SHALL resolve fwd(rs) in this order: rs==0 -> 0; s2_valid && S2.wen && S2.rd==rs -> S2.result; i_wb_valid && i_wb_rd==rs -> i_wb_data; else the stored data.
REQ-021 SHALL, with FWD_EN=0, make fwd(rs) return the stored data, or 0 for rs==0.
REQ-022 SHALL, while S1 is held (s1_valid && !s1_adv), overwrite the stored rs1/rs2 data with i_wb_data when i_wb_valid && i_wb_rd matches a nonzero rs, so no forward is lost during a stall.
REQ-023 SHALL, on i_flush, clear s1_valid and s2_valid at the next edge.
REQ-024 SHALL give i_flush priority over accept and advance, so no instruction enters or moves that cycle.
REQ-025 SHALL drive o_ex_valid/o_ex_rd/o_ex_wen/o_ex_result/o_ex_zero directly from S2 and keep them stable while o_ex_valid && !i_ex_ready.
REQ-026 SHALL ignore i_dec_* when i_dec_valid is low, and ignore i_wb_* when i_wb_valid is low.

Reset
REQ-027 SHALL, while i_rst is high, clear all S1/S2 contents and valids to 0 asynchronously.
REQ-028 SHALL hold every output at 0 during reset, except o_dec_ready, which is 1 when i_flush is low.
REQ-029 SHALL resume accepting on the first rising edge after i_rst deasserts, and any instruction in flight at reset is discarded.

Verification
REQ-030 Stream: accept cmd 8'h1, a=5, b=imm 7, i_ex_ready=1 -> o_ex_valid 2 cycles later, result 12, zero 0.
REQ-031 Back-to-back dependency: add x1=3+4, then sub x2=x1-7 -> second result 0, o_ex_zero 1, with no bubble.
REQ-032 WB forward during stall: hold i_ex_ready=0 with S1 waiting on rs1=x5, pulse wb x5=0x10, release -> result uses 0x10.
REQ-033 Backpressure: i_ex_ready=0 for 4 cycles with continuous input -> S2 and S1 held, o_dec_ready 0, outputs stable, no drop or duplicate.
REQ-034 Flush with both slots full while i_dec_valid=1 -> next cycle s1/s2 empty, o_ex_valid 0, flushed-cycle input not accepted.
REQ-035 Async reset mid-stream -> outputs 0 immediately without a clock, and an x0 operand reads 0 despite wb to rd=0.
